sram_access_ctrl: RTL and testbench

//  Load/store front end for the on-chip data SRAM. Accepts one byte/halfword/word request at a time over a

---
 rtl/sram_access_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
//   Load/store front end for the on-chip data SRAM. Takes one byte/halfword/word
//   request at a time, drives a registered SRAM port, and returns one response per
//   request. Loads capture the SRAM's registered read data one cycle after the
//   access, then align and extend it. Misaligned, out-of-range and illegal-size
//   requests are answered with an error and never reach the SRAM.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  request handshake (ready only while idle)
//   req_we_i, req_size_i,      store/load, size (00 B, 01 H, 10 W, 11 illegal),
//   req_signed_i, req_addr_i,  sign-extend select, byte address,
//   req_wdata_i                right-justified store data
//   resp_valid_o / resp_ready_i response handshake
//   resp_rdata_o, resp_err_o   extended load data (0 for stores/errors), error flag
//   sram_ce_o, sram_we_o,      registered SRAM port; addr is word aligned,
//   sram_addr_o, sram_sel_o,   sel[3] covers data[31:24] (big-endian lanes),
//   sram_data_o                store data replicated across lanes
//   sram_data_i                SRAM read data, valid the cycle after a read access
module sram_access_ctrl #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        sram_ce_o,
    output logic        sram_we_o,
    output logic [31:0] sram_addr_o,
    output logic [3:0]  sram_sel_o,
    output logic [31:0] sram_data_o,
    input  logic [31:0] sram_data_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StCapture, StResp} state_e;

    state_e      state_q, state_d;
    logic        sram_ce_q, sram_ce_d;
    logic        sram_we_q, sram_we_d;
    logic [31:0] sram_addr_q, sram_addr_d;
    logic [3:0]  sram_sel_q, sram_sel_d;
    logic [31:0] sram_data_q, sram_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    // Load shape kept for the capture cycle
    logic [1:0]  ld_size_q, ld_size_d;
    logic        ld_signed_q, ld_signed_d;
    logic [1:0]  ld_off_q, ld_off_d;

    logic        req_err;
    logic [3:0]  req_sel;
    logic [31:0] req_wrep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Request decode: error detection, lane select, write replication
    always_comb begin
        req_err  = (|req_addr_i[31:ADDR_W]);
        req_sel  = 4'b0000;
        req_wrep = req_wdata_i;
        unique case (req_size_i)
            2'b00: begin
                req_wrep = {4{req_wdata_i[7:0]}};
                unique case (req_addr_i[1:0])
                    2'b00: req_sel = 4'b1000;
                    2'b01: req_sel = 4'b0100;
                    2'b10: req_sel = 4'b0010;
                    2'b11: req_sel = 4'b0001;
                endcase
            end
            2'b01: begin
                req_wrep = {2{req_wdata_i[15:0]}};
                req_sel  = req_addr_i[1] ? 4'b0011 : 4'b1100;
                if (req_addr_i[0]) req_err = 1'b1;
            end
            2'b10: begin
                req_sel = 4'b1111;
                if (req_addr_i[1:0] != 2'b00) req_err = 1'b1;
            end
            2'b11: req_err = 1'b1;
        endcase
    end

    // Load alignment: move the addressed big-endian lane(s) down to bit 0, then extend
    always_comb begin
        ld_byte = sram_data_i[31:24];
        unique case (ld_off_q)
            2'b00: ld_byte = sram_data_i[31:24];
            2'b01: ld_byte = sram_data_i[23:16];
            2'b10: ld_byte = sram_data_i[15:8];
            2'b11: ld_byte = sram_data_i[7:0];
        endcase
        ld_half = ld_off_q[1] ? sram_data_i[15:0] : sram_data_i[31:16];
        ld_ext  = sram_data_i;
        if (ld_size_q == 2'b00) begin
            ld_ext = {{24{ld_signed_q & ld_byte[7]}}, ld_byte};
        end else if (ld_size_q == 2'b01) begin
            ld_ext = {{16{ld_signed_q & ld_half[15]}}, ld_half};
        end
    end

    always_comb begin
        state_d      = state_q;
        sram_ce_d    = sram_ce_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_sel_d   = sram_sel_q;
        sram_data_d  = sram_data_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        ld_size_d    = ld_size_q;
        ld_signed_d  = ld_signed_q;
        ld_off_d     = ld_off_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                        state_d      = StResp;
                    end else begin
                        sram_ce_d   = 1'b1;
                        sram_we_d   = req_we_i;
                        sram_addr_d = {req_addr_i[31:2], 2'b00};
                        sram_sel_d  = req_sel;
                        sram_data_d = req_wrep;
                        ld_size_d   = req_size_i;
                        ld_signed_d = req_signed_i;
                        ld_off_d    = req_addr_i[1:0];
                        state_d     = StAccess;
                    end
                end
            end
            StAccess: begin
                // SRAM samples its port at this edge; drop the strobes, keep addr
                sram_ce_d  = 1'b0;
                sram_we_d  = 1'b0;
                sram_sel_d = 4'b0000;
                if (sram_we_q) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                    state_d      = StResp;
                end else begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = ld_ext;
                state_d      = StResp;
            end
            StResp: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                    state_d      = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sram_ce_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= 32'h0;
            sram_sel_q   <= 4'b0000;
            sram_data_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            ld_size_q    <= 2'b00;
            ld_signed_q  <= 1'b0;
            ld_off_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            sram_ce_q    <= sram_ce_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_sel_q   <= sram_sel_d;
            sram_data_q  <= sram_data_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ld_size_q    <= ld_size_d;
            ld_signed_q  <= ld_signed_d;
            ld_off_q     <= ld_off_d;
        end
    end

    // Gated by rst_n so ready reads 0 while reset is held
    assign req_ready_o  = rst_n && (state_q == StIdle);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign sram_ce_o    = sram_ce_q;
    assign sram_we_o    = sram_we_q;
    assign sram_addr_o  = sram_addr_q;
    assign sram_sel_o   = sram_sel_q;
    assign sram_data_o  = sram_data_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_signed_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        sram_ce_o;
    logic        sram_we_o;
    logic [31:0] sram_addr_o;
    logic [3:0]  sram_sel_o;
    logic [31:0] sram_data_o;
    logic [31:0] sram_data_i = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    sram_access_ctrl #(.ADDR_W(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_size_i   (req_size_i),
        .req_signed_i (req_signed_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .sram_ce_o    (sram_ce_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_sel_o   (sram_sel_o),
        .sram_data_o  (sram_data_o),
        .sram_data_i  (sram_data_i)
    );

    always #5 clk = ~clk;

    // SRAM model plus a log of what it sampled
    logic [31:0] mem [256];
    int          ce_cnt = 0;
    logic        last_we = 1'b0;
    logic [3:0]  last_sel = 4'h0;
    logic [31:0] last_data = 32'h0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_ce_o) begin
            if (sram_we_o) mem[sram_addr_o[9:2]] <= merge(mem[sram_addr_o[9:2]], sram_data_o,
                                                          sram_sel_o);
            else sram_data_i <= mem[sram_addr_o[9:2]];
            ce_cnt    <= ce_cnt + 1;
            last_we   <= sram_we_o;
            last_sel  <= sram_sel_o;
            last_data <= sram_data_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        check("ready_before_req", {31'h0, req_ready_o}, 32'h1);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_size_i   = size;
        req_signed_i = sgn;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    // Issues one request, measures latency, optionally back-pressures, then completes it
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat);
        int ce0;
        int lat;
        logic [31:0] rd;
        ce0 = ce_cnt;
        resp_ready_i = (hold == 0);
        start_req(we, size, sgn, addr, wdata);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid_o && lat < 10);
        if (!resp_valid_o) begin
            check({tag, "_timeout"}, {31'h0, resp_valid_o}, 32'h1);
        end else begin
            check({tag, "_lat"}, lat, exp_lat);
            check({tag, "_rdata"}, resp_rdata_o, exp_rdata);
            check({tag, "_err"}, {31'h0, resp_err_o}, {31'h0, exp_err});
            check({tag, "_ce_pulses"}, ce_cnt - ce0, exp_err ? 0 : 1);
        end
        rd = resp_rdata_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'h0, resp_valid_o}, 32'h1);
            check({tag, "_hold_rdata"}, resp_rdata_o, rd);
            check({tag, "_hold_ready"}, {31'h0, req_ready_o}, 32'h0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_released"}, {31'h0, resp_valid_o}, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {24'h0, req_ready_o, resp_valid_o, resp_err_o, sram_ce_o,
                              sram_we_o, 3'b000}, 32'h0);
        check({tag, "_rdata"}, resp_rdata_o, 32'h0);
        check({tag, "_addr"}, sram_addr_o, 32'h0);
        check({tag, "_sel"}, {28'h0, sram_sel_o}, 32'h0);
        check({tag, "_wdata"}, sram_data_o, 32'h0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_after_reset", {31'h0, req_ready_o}, 32'h1);

        // 1: word store
        do_req("st_w", 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 0, 32'h0, 1'b0, 2);
        check("st_w_sram", {last_we, 3'b000, last_sel, 24'h0}, {1'b1, 3'b000, 4'hF, 24'h0});
        check("st_w_data", last_data, 32'hDEADBEEF);

        // 2: byte store then loads
        do_req("st_b", 1'b1, 2'b00, 1'b0, 32'h013, 32'h0000005A, 0, 32'h0, 1'b0, 2);
        check("st_b_sel", {28'h0, last_sel}, 32'h1);
        check("st_b_data", last_data, 32'h5A5A5A5A);
        do_req("ld_sb13", 1'b0, 2'b00, 1'b1, 32'h013, 32'h0, 0, 32'h0000005A, 1'b0, 3);
        check("ld_sb13_sel", {28'h0, last_sel}, 32'h1);
        do_req("ld_w10", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 0, 32'hDEADBE5A, 1'b0, 3);

        // 3: halfword and byte extension
        do_req("ld_sh10", 1'b0, 2'b01, 1'b1, 32'h010, 32'h0, 0, 32'hFFFFDEAD, 1'b0, 3);
        do_req("ld_uh10", 1'b0, 2'b01, 1'b0, 32'h010, 32'h0, 0, 32'h0000DEAD, 1'b0, 3);
        do_req("ld_uh12", 1'b0, 2'b01, 1'b0, 32'h012, 32'h0, 0, 32'h0000BE5A, 1'b0, 3);
        do_req("ld_sb10", 1'b0, 2'b00, 1'b1, 32'h010, 32'h0, 0, 32'hFFFFFFDE, 1'b0, 3);
        do_req("ld_ub11", 1'b0, 2'b00, 1'b0, 32'h011, 32'h0, 0, 32'h000000AD, 1'b0, 3);
        do_req("st_h12", 1'b1, 2'b01, 1'b0, 32'h012, 32'hFFFF1234, 0, 32'h0, 1'b0, 2);
        check("st_h12_sel", {28'h0, last_sel}, 32'h3);
        check("st_h12_data", last_data, 32'h12341234);
        do_req("ld_w10b", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 0, 32'hDEAD1234, 1'b0, 3);

        // 4: errors
        do_req("err_h11", 1'b0, 2'b01, 1'b0, 32'h011, 32'h0, 0, 32'h0, 1'b1, 1);
        do_req("err_w12", 1'b0, 2'b10, 1'b0, 32'h012, 32'h0, 0, 32'h0, 1'b1, 1);
        do_req("err_sz3", 1'b0, 2'b11, 1'b0, 32'h010, 32'h0, 0, 32'h0, 1'b1, 1);
        do_req("err_oor", 1'b1, 2'b10, 1'b0, 32'h400, 32'h11111111, 0, 32'h0, 1'b1, 1);
        do_req("ld_after_err", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 0, 32'hDEAD1234, 1'b0, 3);

        // 5: backpressure
        do_req("bp", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 5, 32'hDEAD1234, 1'b0, 3);

        // 6a: reset during ACCESS of a load
        start_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
        check("rstA_in_access", {31'h0, sram_ce_o}, 32'h1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("rstA");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rstA_ready", {31'h0, req_ready_o}, 32'h1);

        // 6b: reset during RESP
        resp_ready_i = 1'b0;
        start_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
        repeat (3) @(negedge clk);
        check("rstB_in_resp", {31'h0, resp_valid_o}, 32'h1);
        rst_n = 1'b0;
        #1 check_all_zero("rstB");
        resp_ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rstB_ready", {31'h0, req_ready_o}, 32'h1);
        do_req("post_rst", 1'b0, 2'b01, 1'b1, 32'h012, 32'h0, 0, 32'h00001234, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
